// File: rtl/sync_decoder.sv
// Video timing decoder: recovers pixel/line position, line and frame totals,
// vsync width and a lock indication from composite sync and blank signals.
module sync_decoder #(
    parameter int HW          = 10,
    parameter int VW          = 10,
    parameter int LOCK_FRAMES = 3
) (
    input  logic          mclk,
    input  logic          reset,
    input  logic          pix_ce,
    input  logic          _hsync,
    input  logic          _vsync,
    input  logic          hblank,
    input  logic          vblank,
    output logic [HW-1:0] xpos,
    output logic [VW-1:0] ypos,
    output logic [HW-1:0] h_total,
    output logic [VW-1:0] v_total,
    output logic [3:0]    vs_lines,
    output logic          de,
    output logic          frame_strobe,
    output logic          locked,
    output logic          overflow
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [HW-1:0] HMAX   = '1;
    localparam logic [VW-1:0] VMAX   = '1;
    localparam logic [3:0]    LOCK_N = 4'(LOCK_FRAMES);

    // Saturating increments: counters stick at all-ones instead of wrapping.
    function automatic logic [HW-1:0] inc_h(input logic [HW-1:0] v);
        return (v == HMAX) ? v : v + HW'(1);
    endfunction

    function automatic logic [VW-1:0] inc_v(input logic [VW-1:0] v);
        return (v == VMAX) ? v : v + VW'(1);
    endfunction

    logic          hs_d;
    logic          vs_d;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_valid;
    logic          line_bad;
    logic [3:0]    vs_acc;
    logic [3:0]    match_cnt;
    logic          ref_ok;
    state_t        state;

    logic          hs_fall;
    logic          vs_fall;
    logic          vs_rise;
    logic [HW-1:0] line_len;
    logic [VW-1:0] frame_len;
    logic          this_bad;
    logic          h_sat_evt;
    logic          v_sat_evt;
    logic          ovf_now;
    logic          frame_ok;

    // Edges are only recognised on pixel-enable cycles.
    assign hs_fall   = pix_ce & hs_d & ~_hsync;
    assign vs_fall   = pix_ce & vs_d & ~_vsync;
    assign vs_rise   = pix_ce & ~vs_d & _vsync;

    // Length of the line / frame that ends on this edge (count includes the current pixel/line).
    assign line_len  = inc_h(hcnt);
    assign frame_len = inc_v(vcnt);

    // The very first hsync fall after reset ends a partial line, so it is never judged.
    assign this_bad  = hs_fall & h_valid & (line_len != h_total);

    // Saturation happens when a counter is asked to advance while already at its maximum.
    assign h_sat_evt = pix_ce & ~hs_fall & (hcnt == HMAX);
    assign v_sat_evt = hs_fall & ~vs_fall & (vcnt == VMAX);
    assign ovf_now   = overflow | h_sat_evt | v_sat_evt;

    // A frame is good when its lines were consistent, nothing saturated and its
    // length matches the previous frame; the first frame tracked has no reference yet.
    assign frame_ok  = ~(line_bad | this_bad) & ~ovf_now & (~ref_ok | (frame_len == v_total));

    assign xpos = hcnt;
    assign ypos = vcnt;

    // Sync history for edge detection and the registered display-enable.
    always_ff @(posedge mclk) begin
        if (reset) begin
            hs_d <= 1'b1;
            vs_d <= 1'b1;
            de   <= 1'b0;
        end else if (pix_ce) begin
            hs_d <= _hsync;
            vs_d <= _vsync;
            de   <= ~hblank & ~vblank;
        end
    end

    // Pixel and line counters, latched totals, line consistency and overflow flags.
    always_ff @(posedge mclk) begin
        if (reset) begin
            hcnt     <= '0;
            vcnt     <= '0;
            h_total  <= '0;
            v_total  <= '0;
            h_valid  <= 1'b0;
            line_bad <= 1'b0;
            overflow <= 1'b0;
        end else if (pix_ce) begin
            if (hs_fall) begin
                hcnt    <= '0;
                h_total <= line_len;
                h_valid <= 1'b1;
            end else begin
                hcnt <= inc_h(hcnt);
            end

            // A coincident vsync fall takes priority over the line increment.
            if (vs_fall) begin
                vcnt    <= '0;
                v_total <= frame_len;
            end else if (hs_fall) begin
                vcnt <= inc_v(vcnt);
            end

            if (vs_fall) begin
                line_bad <= 1'b0;
            end else if (this_bad) begin
                line_bad <= 1'b1;
            end

            if (h_sat_evt || v_sat_evt) begin
                overflow <= 1'b1;
            end
        end
    end

    // Vsync width in lines: accumulate while _vsync is low, publish on its rising edge.
    always_ff @(posedge mclk) begin
        if (reset) begin
            vs_acc   <= '0;
            vs_lines <= '0;
        end else if (pix_ce) begin
            if (vs_fall) begin
                vs_acc <= hs_fall ? 4'd1 : 4'd0;
            end else if (hs_fall && !_vsync && vs_acc != 4'hF) begin
                vs_acc <= vs_acc + 4'd1;
            end

            if (vs_rise) begin
                vs_lines <= vs_acc;
            end
        end
    end

    // Lock state machine, evaluated once per accepted vsync fall.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state        <= SEARCH;
            match_cnt    <= '0;
            ref_ok       <= 1'b0;
            locked       <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            if (pix_ce) begin
                if (v_sat_evt) begin
                    // Vsync has gone missing long enough to saturate the line counter.
                    state     <= SEARCH;
                    match_cnt <= '0;
                    ref_ok    <= 1'b0;
                    locked    <= 1'b0;
                end else if (vs_fall) begin
                    frame_strobe <= 1'b1;
                    case (state)
                        SEARCH: begin
                            // The frame ending here started mid-way, so it is discarded.
                            state     <= TRACK;
                            match_cnt <= '0;
                            ref_ok    <= 1'b0;
                            locked    <= 1'b0;
                        end
                        TRACK: begin
                            ref_ok <= 1'b1;
                            if (frame_ok) begin
                                match_cnt <= match_cnt + 4'd1;
                                if (match_cnt + 4'd1 == LOCK_N) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                match_cnt <= '0;
                            end
                        end
                        LOCKED: begin
                            if (!frame_ok) begin
                                state     <= SEARCH;
                                match_cnt <= '0;
                                locked    <= 1'b0;
                            end
                        end
                        default: begin
                            state     <= SEARCH;
                            match_cnt <= '0;
                            ref_ok    <= 1'b0;
                            locked    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_decoder.sv
// Testbench for sync_decoder: drives synthetic video timing with random
// pixel-enable spacing and checks each frame strobe against a frame-level model.
module tb_sync_decoder;

    localparam int HW          = 10;
    localparam int VW          = 10;
    localparam int LOCK_FRAMES = 3;
    localparam int LINE_LEN    = 32;

    logic          mclk   = 1'b0;
    logic          reset  = 1'b1;
    logic          pix_ce = 1'b0;
    logic          hs_in  = 1'b1;
    logic          vs_in  = 1'b1;
    logic          hb_in  = 1'b1;
    logic          vb_in  = 1'b1;
    logic [HW-1:0] xpos;
    logic [VW-1:0] ypos;
    logic [HW-1:0] h_total;
    logic [VW-1:0] v_total;
    logic [3:0]    vs_lines;
    logic          de;
    logic          frame_strobe;
    logic          locked;
    logic          overflow;

    sync_decoder #(
        .HW          (HW),
        .VW          (VW),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) dut (
        .mclk         (mclk),
        .reset        (reset),
        .pix_ce       (pix_ce),
        ._hsync       (hs_in),
        ._vsync       (vs_in),
        .hblank       (hb_in),
        .vblank       (vb_in),
        .xpos         (xpos),
        .ypos         (ypos),
        .h_total      (h_total),
        .v_total      (v_total),
        .vs_lines     (vs_lines),
        .de           (de),
        .frame_strobe (frame_strobe),
        .locked       (locked),
        .overflow     (overflow)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit chk_vt;
        int vt;
        bit chk_ht;
        int ht;
        int vsl;
        int lk;
        int ovf;
    } exp_t;

    exp_t sb[$];

    // Frame-level reference state
    bit m_search, m_locked, m_ref_ok, m_ovf, m_seen_line, m_frame_bad, m_first_fall;
    int m_run, m_prev_vt, m_last_len, m_lines, m_vsw, cur_len;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_search     = 1;
        m_locked     = 0;
        m_ref_ok     = 0;
        m_ovf        = 0;
        m_seen_line  = 0;
        m_frame_bad  = 0;
        m_first_fall = 1;
        m_run        = 0;
        m_prev_vt    = 0;
        m_last_len   = -1;
        m_lines      = 0;
        m_vsw        = 0;
        cur_len      = -1;
    endtask

    // Called at the first pixel of every line (an hsync fall), optionally also a vsync fall.
    task automatic model_line_start(input bit vs_fall);
        exp_t e;
        int   vt;
        bit   ok;
        if (m_seen_line && cur_len != m_last_len) m_frame_bad = 1;
        m_seen_line = 1;
        m_last_len  = cur_len;
        if (vs_fall) begin
            vt = m_lines;
            ok = !m_frame_bad && !m_ovf && (!m_ref_ok || vt == m_prev_vt);
            if (m_search) begin
                m_search = 0; m_run = 0; m_ref_ok = 0; m_locked = 0;
            end else if (m_locked) begin
                if (!ok) begin m_search = 1; m_locked = 0; end
            end else begin
                m_ref_ok = 1;
                if (ok) begin
                    m_run++;
                    if (m_run == LOCK_FRAMES) m_locked = 1;
                end else begin
                    m_run = 0;
                end
            end
            e.chk_vt = !m_first_fall;
            e.vt     = vt;
            e.chk_ht = (m_last_len >= 0);
            e.ht     = m_last_len;
            e.vsl    = m_vsw;
            e.lk     = m_locked;
            e.ovf    = m_ovf;
            sb.push_back(e);
            m_prev_vt    = vt;
            m_first_fall = 0;
            m_frame_bad  = 0;
            m_lines      = 1;
        end else begin
            m_lines++;
        end
        cur_len = 0;
    endtask

    task automatic pix(input logic hs, input logic vs, input logic hb, input logic vb);
        hs_in  = hs;
        vs_in  = vs;
        hb_in  = hb;
        vb_in  = vb;
        pix_ce = 1'b1;
        @(posedge mclk); #1;
        pix_ce = 1'b0;
        if (cur_len >= 0) cur_len++;
        repeat ($urandom_range(0, 2)) begin
            @(posedge mclk); #1;
        end
    endtask

    task automatic gen_line(input int len, input bit vs_low, input bit vb, input bit vs_fall);
        model_line_start(vs_fall);
        for (int p = 0; p < len; p++)
            pix((p < 4) ? 1'b0 : 1'b1, vs_low ? 1'b0 : 1'b1, (p >= len - 6), vb);
    endtask

    // One frame of n lines; vsync falls at line 4 for w lines; bad_ln gets one pixel less.
    task automatic gen_frame(input int n, input int w, input int bad_ln);
        for (int ln = 0; ln < n; ln++) begin
            if (ln == 4 + w) m_vsw = (w > 15) ? 15 : w;
            gen_line((ln == bad_ln) ? LINE_LEN - 1 : LINE_LEN,
                     (ln >= 4 && ln < 4 + w), (ln < 2 || ln >= n - 3), (ln == 4));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".xpos"},         int'(xpos),         0);
        check({tag, ".ypos"},         int'(ypos),         0);
        check({tag, ".h_total"},      int'(h_total),      0);
        check({tag, ".v_total"},      int'(v_total),      0);
        check({tag, ".vs_lines"},     int'(vs_lines),     0);
        check({tag, ".de"},           int'(de),           0);
        check({tag, ".frame_strobe"}, int'(frame_strobe), 0);
        check({tag, ".locked"},       int'(locked),       0);
        check({tag, ".overflow"},     int'(overflow),     0);
    endtask

    task automatic do_reset(input string tag);
        hs_in  = 1'b1;
        vs_in  = 1'b1;
        pix_ce = 1'b0;
        reset  = 1'b1;
        @(posedge mclk);
        model_reset();
        @(negedge mclk);
        check_zero(tag);
        @(posedge mclk); #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every frame strobe consumes one expected frame record.
    always @(negedge mclk) begin
        exp_t e;
        if (!reset && frame_strobe) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe: got unexpected frame_strobe, expected none queued at %0t", $time);
            end else begin
                e = sb.pop_front();
                if (e.chk_vt) check("strobe.v_total", int'(v_total), e.vt);
                if (e.chk_ht) check("strobe.h_total", int'(h_total), e.ht);
                check("strobe.vs_lines", int'(vs_lines), e.vsl);
                check("strobe.locked",   int'(locked),   e.lk);
                check("strobe.overflow", int'(overflow), e.ovf);
                check("strobe.xpos",     int'(xpos),     0);
                check("strobe.ypos",     int'(ypos),     0);
            end
        end
    end

    initial begin
        int n, w, bad;
        logic [1:0] blank_tab [4];
        blank_tab[0] = 2'b00;
        blank_tab[1] = 2'b01;
        blank_tab[2] = 2'b10;
        blank_tab[3] = 2'b11;

        model_reset();
        repeat (3) @(posedge mclk);
        #1;
        do_reset("reset");

        // Display enable for each blank combination
        foreach (blank_tab[i]) begin
            pix(1'b1, 1'b1, blank_tab[i][1], blank_tab[i][0]);
            @(negedge mclk);
            check("de", int'(de), (blank_tab[i] == 2'b00) ? 1 : 0);
            @(posedge mclk); #1;
        end

        // Stable timing: lock on the 4th vsync fall after reset
        for (int f = 0; f < 5; f++) gen_frame(20, 4, -1);

        // One long frame drops lock; re-lock after 1+3 good frames
        gen_frame(21, 4, -1);
        for (int f = 0; f < 5; f++) gen_frame(20, 4, -1);

        // One short line mid-frame drops lock at the next vsync fall
        gen_frame(20, 4, 10);
        for (int f = 0; f < 5; f++) gen_frame(20, 4, -1);

        // Mid-line: pix_ce idle holds position, then reset clears everything
        model_line_start(1'b0);
        for (int p = 0; p < 10; p++) pix((p < 4) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (5) @(posedge mclk);
        @(negedge mclk);
        check("hold.xpos", int'(xpos), 9);
        check("hold.locked", int'(locked), int'(m_locked));
        @(posedge mclk); #1;
        do_reset("midline_reset");

        // Randomised frame lengths, vsync widths and occasional bad lines
        for (int f = 0; f < 8; f++) begin
            n   = ($urandom_range(0, 3) == 0) ? 21 : 20;
            w   = $urandom_range(2, 6);
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 15) : -1;
            gen_frame(n, w, bad);
        end

        // Missing hsync saturates the pixel counter; overflow is sticky and blocks lock
        do_reset("pre_overflow_reset");
        for (int p = 0; p < 1100; p++) pix(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge mclk);
        check("sat.xpos", int'(xpos), 1023);
        check("sat.overflow", int'(overflow), 1);
        @(posedge mclk); #1;
        m_ovf = 1;
        for (int f = 0; f < 5; f++) gen_frame(20, 4, -1);
        @(negedge mclk);
        check("sat.locked", int'(locked), 0);
        @(posedge mclk); #1;
        do_reset("final_reset");

        repeat (4) @(posedge mclk);
        check("pending_frames", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
